// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the two-digit BCD countdown timer.
//   state_e   : controller states (IDLE, RUN)
//   BCD_MAX   : largest legal BCD digit value
//   BCD_ZERO  : zero digit
//   bcd_valid : true when a 4-bit code is a legal BCD digit
package bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: combinational single-digit BCD decrement.
//   d_in       : current digit (BCD)
//   dec_en     : request a decrement of this digit
//   d_out      : decremented digit (0 wraps to 9), or d_in when dec_en is low
//   borrow_out : high when a decrement wrapped this digit from 0 to 9
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [3:0] d_in,
  input  logic       dec_en,
  output logic [3:0] d_out,
  output logic       borrow_out
);

  logic at_zero;

  assign at_zero    = (d_in == BCD_ZERO);
  assign borrow_out = dec_en & at_zero;

  always_comb begin
    d_out = d_in;
    if (dec_en) begin
      d_out = at_zero ? BCD_MAX : (d_in - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_countdown_99.sv
// bcd_countdown_99: loadable two-digit BCD countdown timer (99..00).
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   load       : strobe, captures load_tens/load_ones as preset and count
//   load_tens  : preset tens digit (BCD)
//   load_ones  : preset ones digit (BCD)
//   start      : strobe, IDLE -> RUN when the count is non-zero
//   pause      : level, holds the count while in RUN
//   tick       : count-enable strobe
//   tens, ones : current count digits (registered)
//   busy       : high while in RUN
//   done       : one-cycle pulse alongside the first 00 display
//   load_err   : one-cycle pulse after a rejected (non-BCD) load
// AUTO_RELOAD=1 keeps running past 00: the tick after 00 restores the preset.
module bcd_countdown_99
  import bcd_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic       load_err
);

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] preset_tens_q, preset_tens_d;
  logic [3:0] preset_ones_q, preset_ones_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       load_err_q, load_err_d;

  logic       run_tick;
  logic [3:0] ones_dec, tens_dec;
  logic       ones_borrow, tens_borrow;
  logic       count_nz;

  // load and start both outrank tick, so a tick alongside either is dropped.
  assign run_tick = (state_q == RUN) & tick & ~pause & ~load & ~start;
  assign count_nz = (tens_q != BCD_ZERO) | (ones_q != BCD_ZERO);

  bcd_digit_dec u_ones_dec (
    .d_in       (ones_q),
    .dec_en     (run_tick),
    .d_out      (ones_dec),
    .borrow_out (ones_borrow)
  );

  bcd_digit_dec u_tens_dec (
    .d_in       (tens_q),
    .dec_en     (ones_borrow),
    .d_out      (tens_dec),
    .borrow_out (tens_borrow)
  );

  always_comb begin
    state_d       = state_q;
    tens_d        = tens_q;
    ones_d        = ones_q;
    preset_tens_d = preset_tens_q;
    preset_ones_d = preset_ones_q;
    done_d        = 1'b0;
    load_err_d    = 1'b0;

    if (load) begin
      if (bcd_valid(load_tens) && bcd_valid(load_ones)) begin
        tens_d        = load_tens;
        ones_d        = load_ones;
        preset_tens_d = load_tens;
        preset_ones_d = load_ones;
        state_d       = IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (start) begin
      if ((state_q == IDLE) && count_nz) begin
        state_d = RUN;
      end
    end else if (run_tick) begin
      // A tens borrow means the count is 00: never wrap to 99.
      if (tens_borrow) begin
        if (AUTO_RELOAD) begin
          tens_d = preset_tens_q;
          ones_d = preset_ones_q;
        end
      end else begin
        tens_d = tens_dec;
        ones_d = ones_dec;
        if ((tens_dec == BCD_ZERO) && (ones_dec == BCD_ZERO)) begin
          done_d = 1'b1;
          if (!AUTO_RELOAD) begin
            state_d = IDLE;
          end
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tens_q        <= BCD_ZERO;
      ones_q        <= BCD_ZERO;
      preset_tens_q <= BCD_ZERO;
      preset_ones_q <= BCD_ZERO;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      preset_tens_q <= preset_tens_d;
      preset_ones_q <= preset_ones_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      load_err_q    <= load_err_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_99.sv
// tb_bcd_countdown_99: directed bench for bcd_countdown_99. Two instances share
// the stimulus: dut0 with AUTO_RELOAD=0, dut1 with AUTO_RELOAD=1.
module tb_bcd_countdown_99;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic       tick;

  logic [3:0] tens0, ones0, tens1, ones1;
  logic       busy0, done0, load_err0, busy1, done1, load_err1;

  int vectors  = 0;
  int errors   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  bcd_countdown_99 #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .start(start), .pause(pause), .tick(tick),
    .tens(tens0), .ones(ones0), .busy(busy0), .done(done0), .load_err(load_err0)
  );

  bcd_countdown_99 #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .start(start), .pause(pause), .tick(tick),
    .tens(tens1), .ones(ones1), .busy(busy1), .done(done1), .load_err(load_err1)
  );

  // Apply one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                      input logic st, input logic ps, input logic tk);
    load = ld; load_tens = lt; load_ones = lo;
    start = st; pause = ps; tick = tk;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int v;
    logic [7:0] exp_cnt;

    reset = 1'b1;
    load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
    start = 1'b0; pause = 1'b0; tick = 1'b0;

    // Reset overrides a same-cycle load/start/tick.
    step(1'b1, 4'd5, 4'd5, 1'b1, 1'b0, 1'b1);
    check("rst_cnt",      {tens0, ones0}, 8'h00);
    check("rst_busy",     {7'd0, busy0}, 8'd0);
    check("rst_done",     {7'd0, done0}, 8'd0);
    check("rst_load_err", {7'd0, load_err0}, 8'd0);
    reset = 1'b0;

    // Full 23 -> 00 countdown.
    step(1'b1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    check("ld23_cnt",  {tens0, ones0}, 8'h23);
    check("ld23_busy", {7'd0, busy0}, 8'd0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    check("st23_busy", {7'd0, busy0}, 8'd1);
    check("st23_cnt",  {tens0, ones0}, 8'h23);
    for (int i = 1; i <= 23; i++) begin
      step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      v = 23 - i;
      exp_cnt = {4'(v / 10), 4'(v % 10)};
      check("cd23_cnt",  {tens0, ones0}, exp_cnt);
      check("cd23_busy", {7'd0, busy0}, {7'd0, (i < 23)});
      check("cd23_done", {7'd0, done0}, {7'd0, (i == 23)});
      if (done0) done_cnt++;
    end
    check("cd23_done_count", 8'(done_cnt), 8'd1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("cd23_hold_cnt",  {tens0, ones0}, 8'h00);
    check("cd23_hold_done", {7'd0, done0}, 8'd0);

    // Borrow path and pause.
    step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("borrow_cnt", {tens0, ones0}, 8'h09);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    check("pause_cnt",  {tens0, ones0}, 8'h09);
    check("pause_busy", {7'd0, busy0}, 8'd1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("resume_cnt", {tens0, ones0}, 8'h08);

    // Invalid load from reset; start with 00 ignored.
    reset = 1'b1;
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 4'hA, 4'd5, 1'b0, 1'b0, 1'b0);
    check("bad_ld_err", {7'd0, load_err0}, 8'd1);
    check("bad_ld_cnt", {tens0, ones0}, 8'h00);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("bad_ld_err_clr", {7'd0, load_err0}, 8'd0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("st00_busy", {7'd0, busy0}, 8'd0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("st00_cnt", {tens0, ones0}, 8'h00);

    // Auto-reload (dut1), with a rejected load that must keep preset 02.
    step(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    check("ar_ld_cnt", {tens1, ones1}, 8'h02);
    step(1'b1, 4'd3, 4'hC, 1'b0, 1'b0, 1'b0);
    check("ar_bad_err", {7'd0, load_err1}, 8'd1);
    check("ar_bad_cnt", {tens1, ones1}, 8'h02);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("ar_st_busy", {7'd0, busy1}, 8'd1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("ar_t1_cnt", {tens1, ones1}, 8'h01);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("ar_t2_cnt",  {tens1, ones1}, 8'h00);
    check("ar_t2_done", {7'd0, done1}, 8'd1);
    check("ar_t2_busy", {7'd0, busy1}, 8'd1);
    check("nr_t2_done", {7'd0, done0}, 8'd1);
    check("nr_t2_busy", {7'd0, busy0}, 8'd0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("ar_t3_cnt",  {tens1, ones1}, 8'h02);
    check("ar_t3_done", {7'd0, done1}, 8'd0);
    check("nr_t3_cnt",  {tens0, ones0}, 8'h00);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("ar_t4_cnt",  {tens1, ones1}, 8'h01);
    check("ar_t4_busy", {7'd0, busy1}, 8'd1);

    // Reset mid-countdown.
    step(1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("r55_cnt", {tens0, ones0}, 8'h52);
    reset = 1'b1;
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    check("r55_rst_cnt",  {tens0, ones0}, 8'h00);
    check("r55_rst_busy", {7'd0, busy0}, 8'd0);
    check("r55_rst_done", {7'd0, done0}, 8'd0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("r55_st_busy", {7'd0, busy0}, 8'd0);
    check("r55_st_done", {7'd0, done0}, 8'd0);

    // Load + start + tick together while running: load wins, aborts, no done.
    step(1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("lst_pre_cnt", {tens0, ones0}, 8'h41);
    step(1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 1'b1);
    check("lst_cnt",  {tens0, ones0}, 8'h37);
    check("lst_busy", {7'd0, busy0}, 8'd0);
    check("lst_done", {7'd0, done0}, 8'd0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("idle_tick_cnt", {tens0, ones0}, 8'h37);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
